if_fetch_unit: RTL

Instruction fetch unit: owns the program counter, issues single-outstanding fetch requests to the Icache, and tags each returned instruction with its PC for the IF/ID boundary. It sits directly upstream of the decode stage. It redirects on taken branches (from EX) and on jal/jalr (from decode). It discards responses that belong to a squashed fetch, and it pauses request issue under flow-control hold.

---
 rtl/if_fetch_unit.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// if_fetch_unit: PC owner and single-outstanding Icache fetcher; tags each
// delivered instruction with its PC and discards responses of squashed fetches.
//
// Parameters:
//   RESET_PC            first fetch address after reset
// Ports:
//   clk, rst            core clock; synchronous active-high reset
//   fc_bk_if_i          hold: suppresses new request issue only
//   ex_branch_flag_i/pc taken-branch redirect from EX (highest priority)
//   id_jump_flag_i/pc   jal/jalr redirect from ID
//   if_req_o/if_addr_o  fetch request and address toward the Icache
//   Icache_ready_i      Icache accepts the request this cycle
//   Icache_data_valid_i response for the outstanding request
//   if_inst_valid_o     live instruction returned this cycle
//   if_pc_o             PC of the outstanding/returning request
//   if_fetch_cnt_o      delivered-instruction count (stats build only)
//   if_drop_cnt_o       discarded-response count (stats build only)
// Build option:
//   IF_FETCH_STATS_EN   when defined, the two counters exist; otherwise
//                       both count outputs are tied to zero.

module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fc_bk_if_i,
  input  logic        ex_branch_flag_i,
  input  logic [31:0] ex_branch_pc_i,
  input  logic        id_jump_flag_i,
  input  logic [31:0] id_jump_pc_i,
  output logic        if_req_o,
  output logic [31:0] if_addr_o,
  input  logic        Icache_ready_i,
  input  logic        Icache_data_valid_i,
  output logic        if_inst_valid_o,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_fetch_cnt_o,
  output logic [31:0] if_drop_cnt_o
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nx;
  logic [31:0] r_pc;
  logic [31:0] w_pc_nx;
  logic [31:0] r_req_pc;
  logic [31:0] w_req_pc_nx;

  logic        w_redir;
  logic [31:0] w_target;
  logic        w_hs;

  assign w_redir = ex_branch_flag_i | id_jump_flag_i;

  // EX is older than ID, so its target wins; targets are word aligned.
  always_comb begin
    w_target = id_jump_pc_i;
    if (ex_branch_flag_i) begin
      w_target = ex_branch_pc_i;
    end
    w_target[1:0] = 2'b00;
  end

  assign w_hs = !fc_bk_if_i && Icache_ready_i;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_REQ;
      r_pc     <= RESET_PC;
      r_req_pc <= RESET_PC;
    end else begin
      r_state  <= w_state_nx;
      r_pc     <= w_pc_nx;
      r_req_pc <= w_req_pc_nx;
    end
  end

  always_comb begin
    w_state_nx      = r_state;
    w_pc_nx         = r_pc;
    w_req_pc_nx     = r_req_pc;
    if_req_o        = 1'b0;
    if_inst_valid_o = 1'b0;

    unique case (r_state)
      S_REQ: begin
        if_req_o = !fc_bk_if_i;
        if (w_hs && !w_redir) begin
          w_req_pc_nx = r_pc;
          w_pc_nx     = r_pc + 32'd4;
          w_state_nx  = S_WAIT;
        end else if (w_hs && w_redir) begin
          // The accepted request is already stale; swallow its response.
          w_pc_nx    = w_target;
          w_state_nx = S_DROP;
        end else if (w_redir) begin
          w_pc_nx = w_target;
        end
      end

      S_WAIT: begin
        if (Icache_data_valid_i) begin
          if_inst_valid_o = !w_redir;
          if (w_redir) begin
            w_pc_nx = w_target;
          end
          w_state_nx = S_REQ;
        end else if (w_redir) begin
          w_pc_nx    = w_target;
          w_state_nx = S_DROP;
        end
      end

      S_DROP: begin
        if (Icache_data_valid_i) begin
          w_state_nx = S_REQ;
        end
        if (w_redir) begin
          w_pc_nx = w_target;
        end
      end

      default: begin
        w_state_nx = S_REQ;
      end
    endcase

    // While reset is held, present the post-reset view so a late
    // response or stale tracking state never leaks downstream.
    if (rst) begin
      if_req_o        = !fc_bk_if_i;
      if_inst_valid_o = 1'b0;
    end
  end

  assign if_addr_o = rst ? RESET_PC : r_pc;
  assign if_pc_o   = rst ? RESET_PC : r_req_pc;

`ifdef IF_FETCH_STATS_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_drop_cnt;
  logic        w_drop;

  // Discards: any response while squashed, or one that collides
  // with a redirect in the same cycle.
  assign w_drop = Icache_data_valid_i &&
                  ((r_state == S_DROP) ||
                   ((r_state == S_WAIT) && w_redir));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_cnt <= 32'h0;
      r_drop_cnt  <= 32'h0;
    end else begin
      if (if_inst_valid_o) begin
        r_fetch_cnt <= r_fetch_cnt + 32'd1;
      end
      if (w_drop) begin
        r_drop_cnt <= r_drop_cnt + 32'd1;
      end
    end
  end

  assign if_fetch_cnt_o = r_fetch_cnt;
  assign if_drop_cnt_o  = r_drop_cnt;
`else
  assign if_fetch_cnt_o = 32'h0;
  assign if_drop_cnt_o  = 32'h0;
`endif

endmodule
